// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the register hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam int unsigned SB_CNT_W = 2;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned VR_RD    = 0;
  localparam int unsigned VR_RS1   = 1;
  localparam int unsigned VR_RS2   = 2;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One tracked architectural register: pending-writer count plus result-ready bit.
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             inc_late_i,
  input  logic             dec_wb_i,
  input  logic             dec_kill_i,
  input  logic             rr_set_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ready_o,
  output logic             nz_d_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [CNT_W+1:0] sum;
  logic             underflow;

  always_comb begin
    sum       = {2'b00, cnt_q} + (CNT_W+2)'(inc_i)
                - (CNT_W+2)'(dec_wb_i) - (CNT_W+2)'(dec_kill_i);
    underflow = sum[CNT_W+1];
    // Negative net result holds at zero; overflow cannot occur while issue is stall-gated.
    if (underflow)     cnt_d = '0;
    else if (sum[CNT_W]) cnt_d = '1;
    else               cnt_d = sum[CNT_W-1:0];

    ready_d = ready_q;
    if (inc_i)                            ready_d = !inc_late_i;
    else if (cnt_d == '0)                 ready_d = 1'b1;
    else if (rr_set_i && cnt_q != '0)     ready_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      assert (!underflow) else $error("sb_entry: decrement of an empty counter");
    end
  end

  assign cnt_o   = cnt_q;
  assign ready_o = ready_q;
  assign nz_d_o  = (cnt_d != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight writers per register and stalls ID on RAW/saturation.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_issue,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic [4:0]  ID_rd,
  input  logic [2:0]  ID_ValidReg,
  input  logic        ID_late,
  input  logic        RR_valid,
  input  logic [4:0]  RR_rd,
  input  logic        WB_retire,
  input  logic [4:0]  WB_rd,
  input  logic        EX_kill,
  input  logic [4:0]  EX_rd,
  input  logic        EX_wr,
  output logic        ID_stall,
  output logic [31:0] busy_mask,
  output logic        sb_empty
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] ready;
  logic [NREGS-1:0] nz_d;
  logic             issue_wr;
  logic [31:0]      busy_mask_q;
  logic             sb_empty_q;

  assign cnt[0]   = '0;
  assign ready[0] = 1'b1;
  assign nz_d[0]  = 1'b0;

  assign issue_wr = ID_issue && !ID_stall && ID_ValidReg[VR_RD];

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (issue_wr && ID_rd == 5'(i)),
      .inc_late_i (ID_late),
      .dec_wb_i   (WB_retire && WB_rd == 5'(i)),
      .dec_kill_i (EX_kill && EX_wr && EX_rd == 5'(i)),
      .rr_set_i   (RR_valid && RR_rd == 5'(i)),
      .cnt_o      (cnt[i]),
      .ready_o    (ready[i]),
      .nz_d_o     (nz_d[i])
    );
  end

  always_comb begin
    ID_stall = 1'b0;
    if (ID_ValidReg[VR_RS1] && ID_rs1 != '0 && cnt[ID_rs1] != '0 && !ready[ID_rs1])
      ID_stall = 1'b1;
    if (ID_ValidReg[VR_RS2] && ID_rs2 != '0 && cnt[ID_rs2] != '0 && !ready[ID_rs2])
      ID_stall = 1'b1;
    if (ID_ValidReg[VR_RD] && ID_rd != '0 && cnt[ID_rd] == CNT_MAX)
      ID_stall = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask_q <= '0;
      sb_empty_q  <= 1'b1;
    end else begin
      busy_mask_q <= nz_d;
      sb_empty_q  <= ~|nz_d;
    end
  end

  assign busy_mask = busy_mask_q;
  assign sb_empty  = sb_empty_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table plus a variable-latency load-use sequence.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, ID_issue, ID_late, RR_valid, WB_retire, EX_kill, EX_wr;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd, RR_rd, WB_rd, EX_rd;
  logic [2:0]  ID_ValidReg;
  logic        ID_stall, sb_empty;
  logic [31:0] busy_mask;

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .ID_issue(ID_issue), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rd(ID_rd), .ID_ValidReg(ID_ValidReg), .ID_late(ID_late),
    .RR_valid(RR_valid), .RR_rd(RR_rd), .WB_retire(WB_retire), .WB_rd(WB_rd),
    .EX_kill(EX_kill), .EX_rd(EX_rd), .EX_wr(EX_wr),
    .ID_stall(ID_stall), .busy_mask(busy_mask), .sb_empty(sb_empty)
  );

  typedef struct {
    logic        rst, issue;
    logic [2:0]  vr;
    logic [4:0]  rs1, rs2, rd;
    logic        late, rrv;
    logic [4:0]  rrd;
    logic        wbv;
    logic [4:0]  wbd;
    logic        kill;
    logic [4:0]  exrd;
    logic        exp_stall;
    logic [31:0] exp_busy;
    logic        exp_empty;
  } step_t;

  typedef struct {
    logic [31:0] busy;
    logic        empty;
    int          idx;
  } post_t;

  step_t tbl[$];
  post_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic step_t mk(input logic r, input logic iss, input logic [2:0] vr,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic late, input logic rrv, input logic [4:0] rrd,
                               input logic wbv, input logic [4:0] wbd,
                               input logic kill, input logic [4:0] exrd,
                               input logic st, input logic [31:0] busy, input logic emp);
    step_t s;
    s.rst = r; s.issue = iss; s.vr = vr; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.late = late; s.rrv = rrv; s.rrd = rrd; s.wbv = wbv; s.wbd = wbd;
    s.kill = kill; s.exrd = exrd;
    s.exp_stall = st; s.exp_busy = busy; s.exp_empty = emp;
    return s;
  endfunction

  task automatic apply(input step_t s, input int idx);
    post_t p;
    @(negedge clk);
    rst = s.rst; ID_issue = s.issue; ID_ValidReg = s.vr;
    ID_rs1 = s.rs1; ID_rs2 = s.rs2; ID_rd = s.rd; ID_late = s.late;
    RR_valid = s.rrv; RR_rd = s.rrd; WB_retire = s.wbv; WB_rd = s.wbd;
    EX_kill = s.kill; EX_wr = s.kill; EX_rd = s.exrd;
    exp_q.push_back('{busy: s.exp_busy, empty: s.exp_empty, idx: idx});
    #1;
    n_cmp++;
    if (ID_stall !== s.exp_stall) begin
      n_bad++;
      $display("FAIL stall step %0d: got %b expected %b", idx, ID_stall, s.exp_stall);
    end
    @(posedge clk);
    #1;
    p = exp_q.pop_front();
    n_cmp++;
    if (busy_mask !== p.busy) begin
      n_bad++;
      $display("FAIL busy_mask step %0d: got %h expected %h", p.idx, busy_mask, p.busy);
    end
    n_cmp++;
    if (sb_empty !== p.empty) begin
      n_bad++;
      $display("FAIL sb_empty step %0d: got %b expected %b", p.idx, sb_empty, p.empty);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ID_issue = 0; ID_ValidReg = 0; ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0;
    ID_late = 0; RR_valid = 0; RR_rd = 0; WB_retire = 0; WB_rd = 0;
    EX_kill = 0; EX_wr = 0; EX_rd = 0;
    repeat (2) @(posedge clk);

    // rst iss vr rs1 rs2 rd late rrv rrd wbv wbd kill exrd | stall busy empty
    tbl.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 0,0, 0,0, 0,32'h0,1));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 0,0, 0,0, 0,32'h0,1));
    // load-use on x5
    tbl.push_back(mk(0,1,3'b001, 0,0, 5,1, 0,0, 0,0, 0,0, 0,32'h20,0));
    tbl.push_back(mk(0,0,3'b111, 5,1, 6,0, 0,0, 0,0, 0,0, 1,32'h20,0));
    tbl.push_back(mk(0,0,3'b111, 5,1, 6,0, 1,5, 0,0, 0,0, 1,32'h20,0));
    tbl.push_back(mk(0,1,3'b111, 5,1, 6,0, 0,0, 0,0, 0,0, 0,32'h60,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,5, 0,0, 0,32'h40,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,6, 0,0, 0,32'h0,1));
    // ALU back-to-back through x5
    tbl.push_back(mk(0,1,3'b001, 0,0, 5,0, 0,0, 0,0, 0,0, 0,32'h20,0));
    tbl.push_back(mk(0,1,3'b111, 5,5, 7,0, 0,0, 0,0, 0,0, 0,32'hA0,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 0,0, 0,0, 0,32'hA0,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,5, 0,0, 0,32'h80,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,7, 0,0, 0,32'h0,1));
    // saturation of x9
    tbl.push_back(mk(0,1,3'b001, 0,0, 9,0, 0,0, 0,0, 0,0, 0,32'h200,0));
    tbl.push_back(mk(0,1,3'b001, 0,0, 9,0, 0,0, 0,0, 0,0, 0,32'h200,0));
    tbl.push_back(mk(0,1,3'b001, 0,0, 9,0, 0,0, 0,0, 0,0, 0,32'h200,0));
    tbl.push_back(mk(0,0,3'b001, 0,0, 9,0, 0,0, 0,0, 0,0, 1,32'h200,0));
    tbl.push_back(mk(0,0,3'b001, 0,0, 9,0, 0,0, 1,9, 0,0, 1,32'h200,0));
    tbl.push_back(mk(0,1,3'b001, 0,0, 9,0, 0,0, 0,0, 0,0, 0,32'h200,0));
    tbl.push_back(mk(0,0,3'b001, 0,0, 9,0, 0,0, 0,0, 0,0, 1,32'h200,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,9, 0,0, 0,32'h200,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,9, 0,0, 0,32'h200,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,9, 0,0, 0,32'h0,1));
    // kill of a late x3 writer, dependent reads via rs2
    tbl.push_back(mk(0,1,3'b001, 0,0, 3,1, 0,0, 0,0, 0,0, 0,32'h8,0));
    tbl.push_back(mk(0,0,3'b100, 0,3, 0,0, 0,0, 0,0, 1,3, 1,32'h0,1));
    tbl.push_back(mk(0,0,3'b100, 0,3, 0,0, 0,0, 0,0, 0,0, 0,32'h0,1));
    // simultaneous issue + retire on x4
    tbl.push_back(mk(0,1,3'b001, 0,0, 4,0, 0,0, 0,0, 0,0, 0,32'h10,0));
    tbl.push_back(mk(0,1,3'b001, 0,0, 4,1, 0,0, 1,4, 0,0, 0,32'h10,0));
    tbl.push_back(mk(0,0,3'b010, 4,0, 0,0, 0,0, 0,0, 0,0, 1,32'h10,0));
    tbl.push_back(mk(0,0,3'b010, 4,0, 0,0, 1,4, 0,0, 0,0, 1,32'h10,0));
    tbl.push_back(mk(0,0,3'b010, 4,0, 0,0, 0,0, 0,0, 0,0, 0,32'h10,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,4, 0,0, 0,32'h0,1));
    // x0 never tracked
    tbl.push_back(mk(0,1,3'b001, 0,0, 0,1, 0,0, 0,0, 0,0, 0,32'h0,1));
    tbl.push_back(mk(0,0,3'b010, 0,0, 0,0, 1,0, 1,0, 0,0, 0,32'h0,1));
    // reset in the middle of a stall, then reset beating an issue
    tbl.push_back(mk(0,1,3'b001, 0,0, 8,1, 0,0, 0,0, 0,0, 0,32'h100,0));
    tbl.push_back(mk(0,0,3'b010, 8,0, 0,0, 0,0, 0,0, 0,0, 1,32'h100,0));
    tbl.push_back(mk(1,0,3'b010, 8,0, 0,0, 1,8, 0,0, 0,0, 1,32'h0,1));
    tbl.push_back(mk(0,0,3'b010, 8,0, 0,0, 0,0, 0,0, 0,0, 0,32'h0,1));
    tbl.push_back(mk(1,1,3'b001, 0,0,11,0, 0,0, 0,0, 0,0, 0,32'h0,1));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 0,0, 0,0, 0,32'h0,1));

    foreach (tbl[i]) apply(tbl[i], i);

    // Load-use on x12 with the forwardable point arriving after a random delay.
    for (int unsigned rep = 0; rep < 3; rep++) begin
      int unsigned d;
      d = $urandom_range(1, 4);
      apply(mk(0,1,3'b001, 0,0,12,1, 0,0, 0,0, 0,0, 0,32'h1000,0), 100 + 10*rep);
      for (int unsigned k = 0; k < d; k++)
        apply(mk(0,0,3'b011,12,0,13,0, 0,0, 0,0, 0,0, 1,32'h1000,0), 101 + 10*rep);
      apply(mk(0,0,3'b011,12,0,13,0, 1,12, 0,0, 0,0, 1,32'h1000,0), 102 + 10*rep);
      apply(mk(0,1,3'b011,12,0,13,0, 0,0, 0,0, 0,0, 0,32'h3000,0), 103 + 10*rep);
      apply(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,12, 0,0, 0,32'h2000,0), 104 + 10*rep);
      apply(mk(0,0,3'b000, 0,0, 0,0, 0,0, 1,13, 0,0, 0,32'h0,1), 105 + 10*rep);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
